// File: rtl/instr_buffer_sq.sv
// Circular instruction buffer between fetch and dispatch: multi-entry push/pop,
// sequence tags per entry, full flush and partial squash back to a kept tag.
module instr_buffer_sq #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned PUSH_WIDTH = 4,
  parameter int unsigned POP_WIDTH  = 3,
  parameter int unsigned DATA_W     = 32,
  localparam int unsigned SEQ_W     = $clog2(DEPTH) + 1,
  localparam int unsigned CW        = $clog2(DEPTH + 1),
  localparam int unsigned PW        = $clog2(PUSH_WIDTH + 1),
  localparam int unsigned OW        = $clog2(POP_WIDTH + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              squash_valid,
  input  logic [SEQ_W-1:0]                  squash_seq,
  input  logic [PW-1:0]                     num_pushes,
  input  logic [PUSH_WIDTH-1:0][DATA_W-1:0] new_ib_entry,
  output logic                              push_accepted,
  input  logic [OW-1:0]                     num_pops,
  output logic [OW-1:0]                     pops_done,
  output logic [POP_WIDTH-1:0][DATA_W-1:0]  dispatch_window,
  output logic [POP_WIDTH-1:0][SEQ_W-1:0]   window_seq,
  output logic [OW-1:0]                     window_valid_count,
  output logic [PW-1:0]                     available_slots,
  output logic                              full,
  output logic                              empty,
  output logic [CW-1:0]                     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head, tail, head_next, tail_next;
  logic [SEQ_W-1:0]  head_seq, tail_seq, head_seq_next, tail_seq_next;
  logic [CW-1:0]     count_next, free_slots;
  logic [SEQ_W-1:0]  sq_dist;
  logic [CW:0]       keep;

  always_comb begin
    free_slots         = CW'(DEPTH) - count;
    available_slots    = (free_slots < CW'(PUSH_WIDTH)) ? PW'(free_slots) : PW'(PUSH_WIDTH);
    full               = (count == CW'(DEPTH));
    empty              = (count == '0);
    window_valid_count = (count < CW'(POP_WIDTH)) ? OW'(count) : OW'(POP_WIDTH);
    push_accepted      = (num_pushes != '0) && (num_pushes <= available_slots)
                         && !flush && !squash_valid;
    if (flush) pops_done = '0;
    else       pops_done = (CW'(num_pops) < count) ? num_pops : OW'(count);
  end

  always_comb begin
    head_next     = head + AW'(pops_done);
    head_seq_next = head_seq + SEQ_W'(pops_done);
    tail_next     = tail;
    tail_seq_next = tail_seq;
    count_next    = count;
    sq_dist       = squash_seq - head_seq;
    keep          = (CW+1)'(sq_dist) + (CW+1)'(1);
    if (flush) begin
      head_next     = '0;
      head_seq_next = '0;
      tail_next     = '0;
      tail_seq_next = '0;
      count_next    = '0;
    end else if (squash_valid) begin
      // Distance is taken from the pre-pop head; if this cycle's pops consume
      // every kept entry the tail collapses onto the new head.
      if (((CW+1)'(sq_dist) < (CW+1)'(count)) && (keep > (CW+1)'(pops_done))) begin
        count_next    = CW'(keep - (CW+1)'(pops_done));
        tail_next     = head + AW'(keep);
        tail_seq_next = squash_seq + SEQ_W'(1);
      end else begin
        count_next    = '0;
        tail_next     = head_next;
        tail_seq_next = head_seq_next;
      end
    end else begin
      count_next = count - CW'(pops_done) + (push_accepted ? CW'(num_pushes) : '0);
      if (push_accepted) begin
        tail_next     = tail + AW'(num_pushes);
        tail_seq_next = tail_seq + SEQ_W'(num_pushes);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      head_seq <= '0;
      tail_seq <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      head     <= head_next;
      tail     <= tail_next;
      head_seq <= head_seq_next;
      tail_seq <= tail_seq_next;
      count    <= count_next;
      if (push_accepted) begin
        for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
          if (i < 32'(num_pushes)) mem[tail + AW'(i)] <= new_ib_entry[i];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < POP_WIDTH; i++) begin
      dispatch_window[i] = '0;
      window_seq[i]      = '0;
      if (i < 32'(window_valid_count)) begin
        dispatch_window[i] = mem[head + AW'(i)];
        window_seq[i]      = head_seq + SEQ_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_instr_buffer_sq.sv
module tb_instr_buffer_sq;

  localparam int unsigned DEPTH      = 32;
  localparam int unsigned PUSH_WIDTH = 4;
  localparam int unsigned POP_WIDTH  = 3;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SEQ_W      = 6;
  localparam int unsigned CW         = 6;
  localparam int unsigned PW         = 3;
  localparam int unsigned OW         = 2;

  logic                              clock = 1'b0;
  logic                              reset = 1'b1;
  logic                              flush = 1'b0;
  logic                              squash_valid = 1'b0;
  logic [SEQ_W-1:0]                  squash_seq = '0;
  logic [PW-1:0]                     num_pushes = '0;
  logic [PUSH_WIDTH-1:0][DATA_W-1:0] new_ib_entry = '0;
  logic                              push_accepted;
  logic [OW-1:0]                     num_pops = '0;
  logic [OW-1:0]                     pops_done;
  logic [POP_WIDTH-1:0][DATA_W-1:0]  dispatch_window;
  logic [POP_WIDTH-1:0][SEQ_W-1:0]   window_seq;
  logic [OW-1:0]                     window_valid_count;
  logic [PW-1:0]                     available_slots;
  logic                              full, empty;
  logic [CW-1:0]                     count;

  instr_buffer_sq #(
    .DEPTH(DEPTH), .PUSH_WIDTH(PUSH_WIDTH), .POP_WIDTH(POP_WIDTH), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .squash_valid(squash_valid),
    .squash_seq(squash_seq), .num_pushes(num_pushes), .new_ib_entry(new_ib_entry),
    .push_accepted(push_accepted), .num_pops(num_pops), .pops_done(pops_done),
    .dispatch_window(dispatch_window), .window_seq(window_seq),
    .window_valid_count(window_valid_count), .available_slots(available_slots),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clock = ~clock;

  typedef enum int {F_COUNT, F_EMPTY, F_FULL, F_AVAIL, F_WVC, F_POPS, F_PACC,
                    F_D0, F_D1, F_D2, F_S0, F_S1, F_S2} field_e;
  typedef struct {
    string           name;
    field_e          f;
    longint unsigned val;
    int unsigned     cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] pkt(input int unsigned k);
    return 32'hC0DE_0000 | k;
  endfunction

  function automatic longint unsigned actual(input field_e f);
    case (f)
      F_COUNT: return 64'(count);
      F_EMPTY: return 64'(empty);
      F_FULL:  return 64'(full);
      F_AVAIL: return 64'(available_slots);
      F_WVC:   return 64'(window_valid_count);
      F_POPS:  return 64'(pops_done);
      F_PACC:  return 64'(push_accepted);
      F_D0:    return 64'(dispatch_window[0]);
      F_D1:    return 64'(dispatch_window[1]);
      F_D2:    return 64'(dispatch_window[2]);
      F_S0:    return 64'(window_seq[0]);
      F_S1:    return 64'(window_seq[1]);
      F_S2:    return 64'(window_seq[2]);
      default: return 64'hDEAD;
    endcase
  endfunction

  task automatic ex(input string name, input field_e f, input longint unsigned v,
                    input int unsigned off);
    exp_t e;
    e.name = name; e.f = f; e.val = v; e.cyc = cyc + off;
    sbq.push_back(e);
  endtask

  task automatic step(input logic fl, input logic sv, input int unsigned ss,
                      input int unsigned np, input int unsigned base, input int unsigned npop);
    flush        = fl;
    squash_valid = sv;
    squash_seq   = SEQ_W'(ss);
    num_pushes   = PW'(np);
    for (int i = 0; i < PUSH_WIDTH; i++) new_ib_entry[i] = pkt(base + 32'(i));
    num_pops     = OW'(npop);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    int unsigned i;
    longint unsigned act;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].cyc <= cyc) begin
        act = actual(sbq[i].f);
        checks++;
        if (act === sbq[i].val) passes++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                      sbq[i].name, cyc, act, sbq[i].val);
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    ex("rst_count", F_COUNT, 0, 0); ex("rst_empty", F_EMPTY, 1, 0);
    ex("rst_full", F_FULL, 0, 0);   ex("rst_avail", F_AVAIL, 4, 0);
    ex("rst_wvc", F_WVC, 0, 0);     ex("rst_d0", F_D0, 0, 0);
    ex("rst_s0", F_S0, 0, 0);       ex("rst_d2", F_D2, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    ex("p4_acc", F_PACC, 1, 0);
    ex("p4_count", F_COUNT, 4, 1); ex("p4_wvc", F_WVC, 3, 1);
    ex("p4_d0", F_D0, 64'(pkt(32'hA)), 1); ex("p4_d1", F_D1, 64'(pkt(32'hB)), 1);
    ex("p4_d2", F_D2, 64'(pkt(32'hC)), 1);
    ex("p4_s0", F_S0, 0, 1); ex("p4_s1", F_S1, 1, 1); ex("p4_s2", F_S2, 2, 1);
    step(0, 0, 0, 4, 32'hA, 0);
    checks++;
    if (count === CW'(4)) passes++;
    else $display("FAIL direct_p4_count: got %0d, expected 4", count);
    checks++;
    if (window_seq[0] === SEQ_W'(0)) passes++;
    else $display("FAIL direct_p4_s0: got %0d, expected 0", window_seq[0]);

    ex("pop2_done", F_POPS, 2, 0);
    ex("pop2_count", F_COUNT, 2, 1); ex("pop2_d0", F_D0, 64'(pkt(32'hC)), 1);
    ex("pop2_s0", F_S0, 2, 1); ex("pop2_wvc", F_WVC, 2, 1);
    step(0, 0, 0, 0, 0, 2);

    ex("ovpop_done", F_POPS, 2, 0);
    ex("ovpop_empty", F_EMPTY, 1, 1); ex("ovpop_wvc", F_WVC, 0, 1);
    ex("ovpop_count", F_COUNT, 0, 1);
    step(0, 0, 0, 0, 0, 3);

    for (int k = 0; k < 6; k++) step(0, 0, 0, 4, 32'h100 + 32'(4 * k), 0);
    step(0, 0, 0, 2, 32'h118, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0, 3);
    ex("adv_count", F_COUNT, 0, 1);
    step(0, 0, 0, 0, 0, 2);

    ex("wrap_count", F_COUNT, 4, 1);
    ex("wrap_d0", F_D0, 64'(pkt(32'hE0)), 1); ex("wrap_d1", F_D1, 64'(pkt(32'hE1)), 1);
    ex("wrap_d2", F_D2, 64'(pkt(32'hE2)), 1);
    ex("wrap_s0", F_S0, 30, 1); ex("wrap_s1", F_S1, 31, 1); ex("wrap_s2", F_S2, 32, 1);
    step(0, 0, 0, 4, 32'hE0, 0);
    ex("wrap_pop_d0", F_D0, 64'(pkt(32'hE3)), 1); ex("wrap_pop_s0", F_S0, 33, 1);
    ex("wrap_pop_wvc", F_WVC, 1, 1);
    step(0, 0, 0, 0, 0, 3);

    for (int k = 0; k < 7; k++) step(0, 0, 0, 4, 32'h200 + 32'(4 * k), 0);
    ex("near_acc", F_PACC, 0, 0); ex("near_avail", F_AVAIL, 3, 0);
    ex("near_count", F_COUNT, 29, 1);
    step(0, 0, 0, 4, 32'h280, 0);
    ex("fill_acc", F_PACC, 1, 0);
    ex("fill_count", F_COUNT, 32, 1); ex("fill_full", F_FULL, 1, 1);
    ex("fill_avail", F_AVAIL, 0, 1);  ex("fill_empty", F_EMPTY, 0, 1);
    step(0, 0, 0, 3, 32'h300, 0);
    ex("nobyp_acc", F_PACC, 0, 0); ex("nobyp_pops", F_POPS, 3, 0);
    ex("nobyp_count", F_COUNT, 29, 1); ex("nobyp_full", F_FULL, 0, 1);
    ex("nobyp_avail", F_AVAIL, 3, 1);
    ex("nobyp_d0", F_D0, 64'(pkt(32'h202)), 1); ex("nobyp_s0", F_S0, 36, 1);
    step(0, 0, 0, 4, 32'h380, 3);

    ex("fl_pops", F_POPS, 0, 0); ex("fl_acc", F_PACC, 0, 0);
    ex("fl_count", F_COUNT, 0, 1); ex("fl_empty", F_EMPTY, 1, 1);
    ex("fl_avail", F_AVAIL, 4, 1); ex("fl_wvc", F_WVC, 0, 1);
    ex("fl_d0", F_D0, 0, 1); ex("fl_s0", F_S0, 0, 1);
    step(1, 1, 5, 4, 32'h400, 3);
    checks++;
    if (count === CW'(0)) passes++;
    else $display("FAIL direct_fl_count: got %0d, expected 0", count);
    ex("postfl_s0", F_S0, 0, 1); ex("postfl_d0", F_D0, 64'(pkt(32'h500)), 1);
    ex("postfl_count", F_COUNT, 1, 1);
    step(0, 0, 0, 1, 32'h500, 0);

    step(0, 0, 0, 4, 32'h600, 0);
    step(0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 4, 32'h700, 0);
    step(0, 0, 0, 4, 32'h704, 0);
    ex("sq_pops", F_POPS, 1, 0); ex("sq_acc", F_PACC, 0, 0);
    ex("sq_count", F_COUNT, 2, 1); ex("sq_wvc", F_WVC, 2, 1);
    ex("sq_s0", F_S0, 6, 1); ex("sq_s1", F_S1, 7, 1);
    ex("sq_d0", F_D0, 64'(pkt(32'h701)), 1); ex("sq_d1", F_D1, 64'(pkt(32'h702)), 1);
    ex("sq_d2", F_D2, 0, 1);
    step(0, 1, 7, 2, 32'h800, 1);
    checks++;
    if (count === CW'(2)) passes++;
    else $display("FAIL direct_sq_count: got %0d, expected 2", count);
    checks++;
    if (window_seq[0] === SEQ_W'(6)) passes++;
    else $display("FAIL direct_sq_s0: got %0d, expected 6", window_seq[0]);
    ex("sqpush_acc", F_PACC, 1, 0);
    ex("sqpush_count", F_COUNT, 3, 1); ex("sqpush_s2", F_S2, 8, 1);
    ex("sqpush_d2", F_D2, 64'(pkt(32'h900)), 1);
    step(0, 0, 0, 1, 32'h900, 0);

    ex("sqall_pops", F_POPS, 1, 0);
    ex("sqall_count", F_COUNT, 0, 1); ex("sqall_empty", F_EMPTY, 1, 1);
    step(0, 1, 20, 0, 0, 1);
    ex("sqall_push_s0", F_S0, 7, 1); ex("sqall_push_d0", F_D0, 64'(pkt(32'hA00)), 1);
    ex("sqall_push_count", F_COUNT, 1, 1);
    step(0, 0, 0, 1, 32'hA00, 0);

    step(0, 0, 0, 4, 32'hB00, 0);
    reset = 1'b1;
    ex("mrst_count", F_COUNT, 0, 1); ex("mrst_empty", F_EMPTY, 1, 1);
    ex("mrst_wvc", F_WVC, 0, 1);     ex("mrst_d0", F_D0, 0, 1);
    ex("mrst_s0", F_S0, 0, 1);       ex("mrst_avail", F_AVAIL, 4, 1);
    step(1, 1, 3, 4, 32'hC00, 2);
    reset = 1'b0;
    ex("postrst_s0", F_S0, 0, 1); ex("postrst_d0", F_D0, 64'(pkt(32'hD00)), 1);
    step(0, 0, 0, 1, 32'hD00, 0);
    step(0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clock);
    #1;
    while (sbq.size() > 0) begin
      checks++;
      $display("FAIL %s: expectation for cycle %0d never compared", sbq[0].name, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
